// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants, FSM state and command types for the text buffer
package disp_pkg;

    localparam int SEG_W     = 7;
    localparam int NUM_CHARS = 64;
    // Scroll window width in characters; the offset never exceeds (MAX_VIS-1)*SEG_W.
    localparam int MAX_VIS   = 9;

    localparam logic [7:0] KEY_BS  = 8'h08;
    localparam logic [7:0] KEY_ESC = 8'h1B;

    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        APPLY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_PRINT = 2'd1,
        CMD_BS    = 2'd2,
        CMD_ESC   = 2'd3
    } cmd_t;

    function automatic cmd_t classify(input logic [7:0] code);
        if (code >= 8'h20 && code <= 8'h7E) begin
            return CMD_PRINT;
        end else if (code == KEY_BS) begin
            return CMD_BS;
        end else if (code == KEY_ESC) begin
            return CMD_ESC;
        end
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/seg_encode.sv
// rtl/seg_encode.sv - combinational ASCII to seven-segment bitmap encoder
//
// Ports:
//   ascii  in  8  ASCII code
//   bitmap out 7  segment bitmap, bit0 = seg a ... bit6 = seg g, active high
module seg_encode
    import disp_pkg::*;
(
    input  logic [7:0]       ascii,
    output logic [SEG_W-1:0] bitmap
);

    always_comb begin
        // Anything without a glyph renders as a dash.
        bitmap = SEG_DASH;
        case (ascii)
            8'h20: bitmap = SEG_BLANK;
            8'h30: bitmap = 7'h3F;
            8'h31: bitmap = 7'h06;
            8'h32: bitmap = 7'h5B;
            8'h33: bitmap = 7'h4F;
            8'h34: bitmap = 7'h66;
            8'h35: bitmap = 7'h6D;
            8'h36: bitmap = 7'h7D;
            8'h37: bitmap = 7'h07;
            8'h38: bitmap = 7'h7F;
            8'h39: bitmap = 7'h6F;
            8'h41, 8'h61: bitmap = 7'h77;
            8'h42, 8'h62: bitmap = 7'h7C;
            8'h43, 8'h63: bitmap = 7'h39;
            8'h44, 8'h64: bitmap = 7'h5E;
            8'h45, 8'h65: bitmap = 7'h79;
            8'h46, 8'h66: bitmap = 7'h71;
            default: bitmap = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_text_buffer.sv
// rtl/disp_text_buffer.sv - key-code text buffer with segment bitmaps and scroll offset
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   key_valid  in   1    key_code valid
//   key_ready  out  1    block can accept a code (high only in IDLE)
//   key_code   in   8    ASCII code
//   num        out  7*NUM_CHARS  packed bitmaps, newest char at [6:0]
//   offset     out  6    bit offset into num, multiple of 7, 0..56
//   count      out  7    number of valid characters
//   full       out  1    count == NUM_CHARS
module disp_text_buffer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCROLL_HZ = 2,
    parameter int NUM_CHARS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [7:0]             key_code,
    output logic [7*NUM_CHARS-1:0] num,
    output logic [5:0]             offset,
    output logic [6:0]             count,
    output logic                   full
);
    import disp_pkg::*;

    localparam int NUM_W = SEG_W * NUM_CHARS;
    localparam int DIV   = CLK_HZ / SCROLL_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    state_t             state_q, state_d;
    logic [7:0]         code_q;
    logic [SEG_W-1:0]   bmp_q;
    logic [SEG_W-1:0]   bmp_enc;
    cmd_t               cmd_q;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [6:0]         count_q, count_d;
    logic               full_q;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [3:0]         pos_q, pos_d;
    logic [3:0]         vis;
    logic [5:0]         offset_q;
    logic               count_chg;

    seg_encode u_seg_encode (
        .ascii  (code_q),
        .bitmap (bmp_enc)
    );

    // FSM next-state and handshake output
    always_comb begin
        state_d   = state_q;
        key_ready = 1'b0;
        case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer update, only meaningful in APPLY
    always_comb begin
        num_d   = num_q;
        count_d = count_q;
        if (state_q == APPLY) begin
            case (cmd_q)
                CMD_PRINT: begin
                    // When full the oldest character is shifted out of the top.
                    num_d = {num_q[NUM_W-SEG_W-1:0], bmp_q};
                    if (count_q < 7'(NUM_CHARS)) begin
                        count_d = count_q + 7'd1;
                    end
                end
                CMD_BS: begin
                    if (count_q != 7'd0) begin
                        num_d   = {{SEG_W{1'b0}}, num_q[NUM_W-1:SEG_W]};
                        count_d = count_q - 7'd1;
                    end
                end
                CMD_ESC: begin
                    num_d   = '0;
                    count_d = 7'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign count_chg = (count_d != count_q);
    assign tick      = (div_q == DIV_W'(DIV - 1));
    assign vis       = (count_q > 7'(MAX_VIS)) ? 4'(MAX_VIS) : count_q[3:0];

    // Scroll position; a count change wins over a tick in the same cycle.
    always_comb begin
        pos_d = pos_q;
        if (count_chg) begin
            pos_d = 4'd0;
        end else if (count_q <= 7'd1) begin
            pos_d = 4'd0;
        end else if (tick) begin
            pos_d = (pos_q >= vis - 4'd1) ? 4'd0 : pos_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            code_q   <= 8'h00;
            bmp_q    <= SEG_BLANK;
            cmd_q    <= CMD_NONE;
            num_q    <= '0;
            count_q  <= 7'd0;
            full_q   <= 1'b0;
            div_q    <= '0;
            pos_q    <= 4'd0;
            offset_q <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && key_valid) begin
                code_q <= key_code;
            end
            if (state_q == LOAD) begin
                bmp_q <= bmp_enc;
                cmd_q <= classify(code_q);
            end
            num_q    <= num_d;
            count_q  <= count_d;
            full_q   <= (count_d == 7'(NUM_CHARS));
            div_q    <= tick ? '0 : div_q + DIV_W'(1);
            pos_q    <= pos_d;
            offset_q <= 6'(pos_d) * 6'd7;
        end
    end

    assign num    = num_q;
    assign count  = count_q;
    assign full   = full_q;
    assign offset = offset_q;

endmodule

// File: tb/tb_disp_text_buffer.sv
// tb/tb_disp_text_buffer.sv - self-checking bench for disp_text_buffer
module tb_disp_text_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [7:0]   key_code = 8'h00;
    logic         key_ready;
    logic [447:0] num;
    logic [5:0]   offset;
    logic [6:0]   count;
    logic         full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] code;
        logic [6:0] exp0;
        logic [6:0] exp1;
        logic [6:0] exp_cnt;
        logic       exp_full;
    } vec_t;

    vec_t vecs[21];

    always #5 clk = ~clk;

    disp_text_buffer #(
        .CLK_HZ    (8),
        .SCROLL_HZ (1),
        .NUM_CHARS (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .num       (num),
        .offset    (offset),
        .count     (count),
        .full      (full)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge after the APPLY edge, so num/count are settled.
    task automatic send(input logic [7:0] code, input bit check_ready);
        int guard = 0;
        @(negedge clk);
        while (!key_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!key_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        if (check_ready) chk("ready_low1", 64'(key_ready), 64'd0);
        @(negedge clk);
        if (check_ready) chk("ready_low2", 64'(key_ready), 64'd0);
        @(negedge clk);
        if (check_ready) chk("ready_back", 64'(key_ready), 64'd1);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send(vecs[i].code, 1'b1);
            chk($sformatf("row%0d_num0", i), 64'(num[6:0]), 64'(vecs[i].exp0));
            chk($sformatf("row%0d_num1", i), 64'(num[13:7]), 64'(vecs[i].exp1));
            chk($sformatf("row%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
            chk($sformatf("row%0d_full", i), 64'(full), 64'(vecs[i].exp_full));
            chk($sformatf("row%0d_offset", i), 64'(offset), 64'd0);
        end
    endtask

    // Watches offset; every change must be the next step of a 0..7*lmax wrap.
    task automatic watch(input int cycles, input int lmax, input string name, output int changes);
        logic [5:0] prev;
        logic [5:0] nxt;
        int bad = 0;
        changes = 0;
        prev = offset;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (offset !== prev) begin
                nxt = (int'(prev) >= 7 * lmax) ? 6'd0 : prev + 6'd7;
                if (offset !== nxt) bad++;
                changes++;
                prev = offset;
            end
        end
        chk({name, "_seq"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int n;
        int bad;

        vecs[0]  = '{8'h31, 7'h06, 7'h00, 7'd1,  1'b0};
        vecs[1]  = '{8'h1B, 7'h00, 7'h00, 7'd0,  1'b0};
        vecs[2]  = '{8'h30, 7'h3F, 7'h00, 7'd1,  1'b0};
        vecs[3]  = '{8'h31, 7'h06, 7'h3F, 7'd2,  1'b0};
        vecs[4]  = '{8'h08, 7'h3F, 7'h00, 7'd1,  1'b0};
        vecs[5]  = '{8'h08, 7'h00, 7'h00, 7'd0,  1'b0};
        vecs[6]  = '{8'h08, 7'h00, 7'h00, 7'd0,  1'b0};
        vecs[7]  = '{8'h1B, 7'h00, 7'h00, 7'd0,  1'b0};
        vecs[8]  = '{8'h41, 7'h77, 7'h00, 7'd1,  1'b0};
        vecs[9]  = '{8'h62, 7'h7C, 7'h77, 7'd2,  1'b0};
        vecs[10] = '{8'h43, 7'h39, 7'h7C, 7'd3,  1'b0};
        vecs[11] = '{8'h64, 7'h5E, 7'h39, 7'd4,  1'b0};
        vecs[12] = '{8'h45, 7'h79, 7'h5E, 7'd5,  1'b0};
        vecs[13] = '{8'h66, 7'h71, 7'h79, 7'd6,  1'b0};
        vecs[14] = '{8'h20, 7'h00, 7'h71, 7'd7,  1'b0};
        vecs[15] = '{8'h7A, 7'h40, 7'h00, 7'd8,  1'b0};
        vecs[16] = '{8'h39, 7'h6F, 7'h40, 7'd9,  1'b0};
        vecs[17] = '{8'h35, 7'h6D, 7'h6F, 7'd10, 1'b0};
        vecs[18] = '{8'h1B, 7'h00, 7'h00, 7'd0,  1'b0};
        vecs[19] = '{8'h7E, 7'h40, 7'h00, 7'd1,  1'b0};
        vecs[20] = '{8'h01, 7'h40, 7'h00, 7'd1,  1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_num", 64'(num == '0), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_offset", 64'(offset), 64'd0);
        chk("rst_ready", 64'(key_ready), 64'd1);
        rst = 1'b0;

        // Single character: offset must stay 0 across three ticks
        run_rows(0, 0);
        watch(24, 0, "t1_offset", n);
        chk("t1_changes", 64'(n), 64'd0);

        // Two characters: offset alternates 0,7 once per 8-cycle tick
        run_rows(1, 3);
        watch(40, 1, "t2_offset", n);
        chk("t2_changes", 64'(n), 64'd5);

        // Backspace down to empty, then once more
        run_rows(4, 6);
        chk("t3_num_zero", 64'(num == '0), 64'd1);

        // Fill past capacity
        send(8'h1B, 1'b0);
        for (int i = 0; i < 65; i++) send(8'h38, 1'b0);
        chk("t4_count", 64'(count), 64'd64);
        chk("t4_full", 64'(full), 64'd1);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (num[7*i +: 7] !== 7'h7F) bad++;
        end
        chk("t4_fields", 64'(bad), 64'd0);
        send(8'h31, 1'b1);
        chk("t4_new_num0", 64'(num[6:0]), 64'h06);
        chk("t4_new_num1", 64'(num[13:7]), 64'h7F);
        chk("t4_new_count", 64'(count), 64'd64);
        chk("t4_new_full", 64'(full), 64'd1);
        watch(80, 8, "t4_offset", n);
        chk("t4_changes", 64'(n), 64'd10);

        // Encodings, ESC at count 10, dash, ignored code
        run_rows(7, 20);

        // Asynchronous reset while APPLY is pending
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 8'h32;
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_num", 64'(num == '0), 64'd1);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_ready", 64'(key_ready), 64'd1);
        key_valid = 1'b1;
        key_code  = 8'h31;
        repeat (3) @(negedge clk);
        chk("t6_hold_count", 64'(count), 64'd0);
        chk("t6_hold_num", 64'(num == '0), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 key_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_after_count", 64'(count), 64'd1);
        chk("t6_after_num0", 64'(num[6:0]), 64'h06);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
